tcp_tx_segment_gen: RTL

Downstream consumer of the TCP connection state manager's transmit-control channel. It accepts one `tcp_pkg::tx_ctrl_t` command at a time (SEND_SYN / SEND_ACK / SEND_FIN) and turns it into a TCP header descriptor for the packet builder. The descriptor carries sequence number, acknowledgement number, flags and window, handed over on a valid/ready interface. It owns the connection's sequence state: SND.NXT from the send side, and RCV.NXT from received-segment reports.

---
 rtl/tcp_pkg.sv | 9 +
 rtl/tcp_tx_segment_gen.sv | 127 ++++++++++++
 2 files changed

// File: rtl/tcp_pkg.sv
// Shared types for the TCP connection datapath.
package tcp_pkg;
  typedef enum logic [1:0] {
    TX_CTRL_NOP = 2'd0,
    SEND_SYN    = 2'd1,
    SEND_ACK    = 2'd2,
    SEND_FIN    = 2'd3
  } tx_ctrl_t;
endpackage

// File: rtl/tcp_tx_segment_gen.sv
// Turns transmit-control commands into TCP header descriptors and tracks
// SND.NXT / RCV.NXT for the connection.
module tcp_tx_segment_gen
  import tcp_pkg::*;
#(
  parameter logic [15:0] WINDOW = 16'd1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  tx_ctrl_t    i_tx_ctrl,
  input  logic        i_tx_ctrl_valid,
  output logic        o_tx_ctrl_ack,
  input  logic [31:0] i_iss,
  input  logic        i_rx_seg_valid,
  input  logic [31:0] i_rx_seq,
  input  logic [15:0] i_rx_len,
  input  logic        i_rx_syn,
  input  logic        i_rx_fin,
  output logic        o_seg_valid,
  input  logic        i_seg_ready,
  output logic [31:0] o_seg_seq,
  output logic [31:0] o_seg_ack,
  output logic [7:0]  o_seg_flags,
  output logic [15:0] o_seg_window,
  output logic [31:0] o_snd_nxt,
  output logic [31:0] o_rcv_nxt,
  output logic        o_rx_ooo
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] snd_nxt_q, snd_nxt_d;
  logic [31:0] rcv_nxt_q, rcv_nxt_d;
  logic [31:0] seq_q, seq_d;
  logic [31:0] ack_q, ack_d;
  logic [7:0]  flags_q, flags_d;
  logic        ooo_q, ooo_d;
  logic        accept, handshake;
  logic [31:0] rx_adv;

  // Sequence space consumed by the received segment, excluding SYN.
  assign rx_adv = {16'd0, i_rx_len} + {31'd0, i_rx_fin};

  assign accept    = i_enable && (state_q == S_IDLE) && i_tx_ctrl_valid &&
                     (i_tx_ctrl != TX_CTRL_NOP);
  assign handshake = (state_q == S_SEND) && i_seg_ready;

  always_comb begin
    state_d   = state_q;
    snd_nxt_d = snd_nxt_q;
    rcv_nxt_d = rcv_nxt_q;
    seq_d     = seq_q;
    ack_d     = ack_q;
    flags_d   = flags_q;
    ooo_d     = 1'b0;

    if (i_rx_seg_valid) begin
      if (i_rx_syn)
        rcv_nxt_d = i_rx_seq + 32'd1 + rx_adv;
      else if (i_rx_seq == rcv_nxt_q)
        rcv_nxt_d = rcv_nxt_q + rx_adv;
      else
        ooo_d = 1'b1;
    end

    // ACK field takes RCV.NXT including a same-cycle rx report.
    if (accept) begin
      state_d = S_SEND;
      case (i_tx_ctrl)
        SEND_SYN: begin seq_d = i_iss;     ack_d = 32'd0;     flags_d = 8'h02; end
        SEND_ACK: begin seq_d = snd_nxt_q; ack_d = rcv_nxt_d; flags_d = 8'h10; end
        SEND_FIN: begin seq_d = snd_nxt_q; ack_d = rcv_nxt_d; flags_d = 8'h11; end
        default:  ;
      endcase
    end

    // SYN and FIN each consume one sequence number; a bare ACK consumes none.
    if (handshake) begin
      state_d   = S_IDLE;
      snd_nxt_d = (flags_q[1] || flags_q[0]) ? seq_q + 32'd1 : seq_q;
    end

    if (!i_enable) begin
      state_d   = S_IDLE;
      snd_nxt_d = 32'd0;
      rcv_nxt_d = 32'd0;
      seq_d     = 32'd0;
      ack_d     = 32'd0;
      flags_d   = 8'h00;
      ooo_d     = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      snd_nxt_q <= 32'd0;
      rcv_nxt_q <= 32'd0;
      seq_q     <= 32'd0;
      ack_q     <= 32'd0;
      flags_q   <= 8'h00;
      ooo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      snd_nxt_q <= snd_nxt_d;
      rcv_nxt_q <= rcv_nxt_d;
      seq_q     <= seq_d;
      ack_q     <= ack_d;
      flags_q   <= flags_d;
      ooo_q     <= ooo_d;
    end
  end

  assign o_tx_ctrl_ack = accept;
  assign o_seg_valid   = (state_q == S_SEND);
  assign o_seg_seq     = seq_q;
  assign o_seg_ack     = ack_q;
  assign o_seg_flags   = flags_q;
  assign o_seg_window  = WINDOW;
  assign o_snd_nxt     = snd_nxt_q;
  assign o_rcv_nxt     = rcv_nxt_q;
  assign o_rx_ooo      = ooo_q;

endmodule
